mul_seq: RTL

//  Iterative shift-add multiplier, parametrised in operand width, one multiplier bit per cycle.

---
 rtl/mul_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per clock, LSB first.
// Supports uxu, sxs and (signed A) x (unsigned B), with valid/ready on both sides.
module mul_seq #(
    parameter int N_BIT    = 4,
    parameter int RES_SIZE = 2 * N_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_BIT-1:0]    A,
    input  logic [N_BIT-1:0]    B,
    input  logic [1:0]          mul_type,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_SIZE-1:0] product,
    output logic                busy
);

    localparam int CNT_W = $clog2(N_BIT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [N_BIT:0]        acc_hi_q, acc_hi_d;
    logic [N_BIT-1:0]      acc_lo_q, acc_lo_d;
    logic [N_BIT-1:0]      a_q, a_d;
    logic [N_BIT-1:0]      b_q, b_d;
    logic                  a_sgn_q, a_sgn_d;
    logic                  b_sgn_q, b_sgn_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RES_SIZE-1:0]   prod_q, prod_d;

    logic [N_BIT:0]        a_ext;
    logic [N_BIT:0]        sum;
    logic                  last_step;

    // Partial-product step: add ext(A), or subtract it on the sign bit of a signed B.
    always_comb begin
        a_ext     = {a_sgn_q & a_q[N_BIT-1], a_q};
        last_step = (cnt_q == CNT_W'(N_BIT - 1));
        sum       = acc_hi_q;
        if (b_q[0]) begin
            if (last_step && b_sgn_q) begin
                sum = acc_hi_q - a_ext;
            end else begin
                sum = acc_hi_q + a_ext;
            end
        end
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d  = state_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        a_d      = a_q;
        b_d      = b_q;
        a_sgn_d  = a_sgn_q;
        b_sgn_d  = b_sgn_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    a_sgn_d  = (mul_type == 2'b01) || (mul_type == 2'b10);
                    b_sgn_d  = (mul_type == 2'b01);
                    acc_hi_d = '0;
                    acc_lo_d = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // B is consumed by shifting it right, so bit 0 is always the current bit.
                acc_hi_d = {a_sgn_q & sum[N_BIT], sum[N_BIT:1]};
                acc_lo_d = {sum[0], acc_lo_q[N_BIT-1:1]};
                b_d      = b_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_step) begin
                    prod_d  = {acc_hi_d[N_BIT-1:0], acc_lo_d};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_sgn_q  <= 1'b0;
            b_sgn_q  <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_sgn_q  <= a_sgn_d;
            b_sgn_q  <= b_sgn_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign product   = prod_q;

endmodule
